axi_addr_demux: RTL
===================

Name: axi_addr_demux

Overview:
- Parametrised AXI4 address-decoding demultiplexer. Routes the single core-side AXI4 master to NUM_M downstream master ports by address range.
- Generalises the fixed two-port split (peripheral vs. memory) of the SoC wrapper to N ports with a programmable map.
- Tracks outstanding transactions per direction and answers unmapped accesses itself with DECERR.
- Sits between the core's AXI master and the SoC wrapper's external AXI ports.

Parameters:
- NUM_M, 2, number of downstream ports (1..8)
- ADDR_W, 64, address width
- DATA_W, 64, data width; STRB = DATA_W/8
- ID_W, 4, AXI ID width
- MAX_OUTS, 4, max outstanding bursts per direction (AW and AR tracked independently)
- M_BASE, {64'h8000_0000, 64'h0}, flattened NUM_M*ADDR_W base addresses; port i at slice i
- M_MASK, {64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_8000_0000}, flattened match masks

Ports:
- sys_clk  in  1  clock
- RSTn  in  1  asynchronous active-low reset
- S_AXI_AW*  in/out  AWID[ID_W] AWADDR[ADDR_W] AWLEN[8] AWSIZE[3] AWBURST[2] AWLOCK AWCACHE[4] AWPROT[3] AWVALID in, AWREADY out; core write address
- S_AXI_W*  in/out  WDATA WSTRB WLAST WVALID in, WREADY out
- S_AXI_B*  out/in  BID BRESP[2] BVALID out, BREADY in
- S_AXI_AR*  in/out  same field set as AW
- S_AXI_R*  out/in  RID RDATA RRESP[2] RLAST RVALID out, RREADY in
- M_AXI_*  mirrored  every S_AXI field widened to NUM_M×width, flattened, port i at slice i; direction opposite to S side

Behaviour:
- Reset: asynchronous on RSTn low. All VALID/READY outputs 0; BRESP, RRESP, RDATA, BID, RID 0; counters 0; locked targets cleared. Reset mid-burst abandons the burst; no recovery handshake.
- Decode (AW and AR, combinational): port i matches when (ADDR & M_MASK[i]) == M_BASE[i]. Lowest matching index wins. No match selects internal error target ERR (index NUM_M).
- Write issue, zero latency:
  - can_aw = (aw_cnt == 0 || aw_sel == w_tgt) && aw_cnt < MAX_OUTS.
  - M_AWVALID[aw_sel] = S_AWVALID & can_aw; S_AWREADY = can_aw & (sel==ERR ? 1 : M_AWREADY[sel]).
  - On AW handshake: w_tgt <= sel, aw_cnt++ and wpend++.
  - A different target with aw_cnt > 0 stalls AW (AWREADY 0) until aw_cnt drains to 0.
- W routing:
  - W forwarded to w_tgt only while wpend > 0; S_WREADY = 0 when wpend == 0 (W never precedes its AW).
  - Handshake with WLAST decrements wpend.
  - ERR target: WREADY = 1, beats discarded.
- B path:
  - Muxed from w_tgt; M_BREADY[w_tgt] = S_BREADY.
  - ERR target: one B per error burst, issued the cycle after its WLAST, BID = captured AWID, BRESP = 2'b11.
  - B handshake decrements aw_cnt.
  - Same-cycle AW accept and B complete: aw_cnt unchanged.
- Read issue: identical scheme using ar_cnt and r_tgt.
- R path:
  - Muxed from r_tgt.
  - ERR target: internal beat counter emits ARLEN+1 beats, RDATA = 0, RRESP = 2'b11, RID = captured ARID, RLAST on final beat. Each beat held until RREADY.
  - RLAST handshake decrements ar_cnt; simultaneous AR accept is a net 0 change.
- Error sink handles one outstanding error burst per direction. A second error AW/AR stalls until the first completes.
- Pass-through fields (LOCK, CACHE, PROT, SIZE, BURST, LEN, ID) are broadcast to all M ports; only VALID is gated.
- Unselected M VALID/READY = 0.
- Counter saturation: at MAX_OUTS, AWREADY/ARREADY = 0 regardless of target.

Test Plan:
- Single write to 0x8000_0040, AWLEN=3 → only port1 AWVALID, 4 W beats reach port1, BRESP 0 returned with the original BID; aw_cnt returns to 0.
- Read to 0x1000_0000 → port0 AR; read to 0x8000_0000 issued while the first is pending → AR stalls until port0 RLAST handshake, then goes to port1.
- Four back-to-back reads to port1 with RVALID held low → fifth AR sees ARREADY 0 (MAX_OUTS = 4); first RLAST releases it the next cycle.
- NUM_M=3, map with no match at 0x4000_0000: AR ARLEN=2, ARID=5 → 3 beats, RDATA 0, RRESP 2'b11, RID 5, RLAST on beat 3; no M_ARVALID asserted.
- Unmapped write, AWLEN=1, AWID=9 → WREADY 1 for 2 beats, then B with BID 9, BRESP 2'b11.
- RSTn pulsed low mid-burst → all VALID/READY outputs 0 asynchronously; after release, a new write completes normally.

Source files
------------

// File: rtl/axi_addr_demux.sv
// axi_addr_demux: routes one AXI4 master to NUM_M downstream ports by address range.
// Port i is selected when (ADDR & M_MASK[i]) == M_BASE[i]; the lowest matching index wins.
// Unmapped accesses go to an internal error sink that answers with DECERR.
// Ports:
//   sys_clk, RSTn  - clock, asynchronous active-low reset
//   S_AXI_*        - core-side slave interface (AW, W, B, AR, R channels)
//   M_AXI_*        - NUM_M flattened master interfaces, port i at slice i
// Outstanding bursts per direction all target one port; switching targets waits for a drain.
module axi_addr_demux #(
  parameter int unsigned NUM_M    = 2,
  parameter int unsigned ADDR_W   = 64,
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned ID_W     = 4,
  parameter int unsigned MAX_OUTS = 4,
  parameter logic [NUM_M*ADDR_W-1:0] M_BASE = {64'h8000_0000, 64'h0},
  parameter logic [NUM_M*ADDR_W-1:0] M_MASK = {64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_8000_0000}
) (
  input  logic                      sys_clk,
  input  logic                      RSTn,
  // core side
  input  logic [ID_W-1:0]           S_AXI_AWID,
  input  logic [ADDR_W-1:0]         S_AXI_AWADDR,
  input  logic [7:0]                S_AXI_AWLEN,
  input  logic [2:0]                S_AXI_AWSIZE,
  input  logic [1:0]                S_AXI_AWBURST,
  input  logic                      S_AXI_AWLOCK,
  input  logic [3:0]                S_AXI_AWCACHE,
  input  logic [2:0]                S_AXI_AWPROT,
  input  logic                      S_AXI_AWVALID,
  output logic                      S_AXI_AWREADY,
  input  logic [DATA_W-1:0]         S_AXI_WDATA,
  input  logic [DATA_W/8-1:0]       S_AXI_WSTRB,
  input  logic                      S_AXI_WLAST,
  input  logic                      S_AXI_WVALID,
  output logic                      S_AXI_WREADY,
  output logic [ID_W-1:0]           S_AXI_BID,
  output logic [1:0]                S_AXI_BRESP,
  output logic                      S_AXI_BVALID,
  input  logic                      S_AXI_BREADY,
  input  logic [ID_W-1:0]           S_AXI_ARID,
  input  logic [ADDR_W-1:0]         S_AXI_ARADDR,
  input  logic [7:0]                S_AXI_ARLEN,
  input  logic [2:0]                S_AXI_ARSIZE,
  input  logic [1:0]                S_AXI_ARBURST,
  input  logic                      S_AXI_ARLOCK,
  input  logic [3:0]                S_AXI_ARCACHE,
  input  logic [2:0]                S_AXI_ARPROT,
  input  logic                      S_AXI_ARVALID,
  output logic                      S_AXI_ARREADY,
  output logic [ID_W-1:0]           S_AXI_RID,
  output logic [DATA_W-1:0]         S_AXI_RDATA,
  output logic [1:0]                S_AXI_RRESP,
  output logic                      S_AXI_RLAST,
  output logic                      S_AXI_RVALID,
  input  logic                      S_AXI_RREADY,
  // downstream ports
  output logic [NUM_M*ID_W-1:0]     M_AXI_AWID,
  output logic [NUM_M*ADDR_W-1:0]   M_AXI_AWADDR,
  output logic [NUM_M*8-1:0]        M_AXI_AWLEN,
  output logic [NUM_M*3-1:0]        M_AXI_AWSIZE,
  output logic [NUM_M*2-1:0]        M_AXI_AWBURST,
  output logic [NUM_M-1:0]          M_AXI_AWLOCK,
  output logic [NUM_M*4-1:0]        M_AXI_AWCACHE,
  output logic [NUM_M*3-1:0]        M_AXI_AWPROT,
  output logic [NUM_M-1:0]          M_AXI_AWVALID,
  input  logic [NUM_M-1:0]          M_AXI_AWREADY,
  output logic [NUM_M*DATA_W-1:0]   M_AXI_WDATA,
  output logic [NUM_M*DATA_W/8-1:0] M_AXI_WSTRB,
  output logic [NUM_M-1:0]          M_AXI_WLAST,
  output logic [NUM_M-1:0]          M_AXI_WVALID,
  input  logic [NUM_M-1:0]          M_AXI_WREADY,
  input  logic [NUM_M*ID_W-1:0]     M_AXI_BID,
  input  logic [NUM_M*2-1:0]        M_AXI_BRESP,
  input  logic [NUM_M-1:0]          M_AXI_BVALID,
  output logic [NUM_M-1:0]          M_AXI_BREADY,
  output logic [NUM_M*ID_W-1:0]     M_AXI_ARID,
  output logic [NUM_M*ADDR_W-1:0]   M_AXI_ARADDR,
  output logic [NUM_M*8-1:0]        M_AXI_ARLEN,
  output logic [NUM_M*3-1:0]        M_AXI_ARSIZE,
  output logic [NUM_M*2-1:0]        M_AXI_ARBURST,
  output logic [NUM_M-1:0]          M_AXI_ARLOCK,
  output logic [NUM_M*4-1:0]        M_AXI_ARCACHE,
  output logic [NUM_M*3-1:0]        M_AXI_ARPROT,
  output logic [NUM_M-1:0]          M_AXI_ARVALID,
  input  logic [NUM_M-1:0]          M_AXI_ARREADY,
  input  logic [NUM_M*ID_W-1:0]     M_AXI_RID,
  input  logic [NUM_M*DATA_W-1:0]   M_AXI_RDATA,
  input  logic [NUM_M*2-1:0]        M_AXI_RRESP,
  input  logic [NUM_M-1:0]          M_AXI_RLAST,
  input  logic [NUM_M-1:0]          M_AXI_RVALID,
  output logic [NUM_M-1:0]          M_AXI_RREADY
);

  localparam int unsigned SelW = $clog2(NUM_M + 1);
  localparam int unsigned CntW = $clog2(MAX_OUTS + 1);
  localparam logic [SelW-1:0] ErrSel = SelW'(NUM_M);
  localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_OUTS);

  function automatic logic [SelW-1:0] decode(input logic [ADDR_W-1:0] addr);
    logic [SelW-1:0] sel;
    sel = ErrSel;
    // Scan downwards so the lowest matching index is the one left standing.
    for (int i = NUM_M - 1; i >= 0; i--) begin
      if ((addr & M_MASK[i*ADDR_W +: ADDR_W]) == M_BASE[i*ADDR_W +: ADDR_W]) sel = SelW'(i);
    end
    return sel;
  endfunction

  // State
  logic [CntW-1:0] aw_cnt_q, aw_cnt_d, wpend_q, wpend_d, ar_cnt_q, ar_cnt_d;
  logic [SelW-1:0] w_tgt_q, r_tgt_q;
  logic            err_bvalid_q, err_ract_q;
  logic [ID_W-1:0] err_bid_q, err_rid_q;
  logic [7:0]      err_rcnt_q;

  // Broadcast pass-through fields; only handshakes are steered.
  assign M_AXI_AWID    = {NUM_M{S_AXI_AWID}};
  assign M_AXI_AWADDR  = {NUM_M{S_AXI_AWADDR}};
  assign M_AXI_AWLEN   = {NUM_M{S_AXI_AWLEN}};
  assign M_AXI_AWSIZE  = {NUM_M{S_AXI_AWSIZE}};
  assign M_AXI_AWBURST = {NUM_M{S_AXI_AWBURST}};
  assign M_AXI_AWLOCK  = {NUM_M{S_AXI_AWLOCK}};
  assign M_AXI_AWCACHE = {NUM_M{S_AXI_AWCACHE}};
  assign M_AXI_AWPROT  = {NUM_M{S_AXI_AWPROT}};
  assign M_AXI_WDATA   = {NUM_M{S_AXI_WDATA}};
  assign M_AXI_WSTRB   = {NUM_M{S_AXI_WSTRB}};
  assign M_AXI_WLAST   = {NUM_M{S_AXI_WLAST}};
  assign M_AXI_ARID    = {NUM_M{S_AXI_ARID}};
  assign M_AXI_ARADDR  = {NUM_M{S_AXI_ARADDR}};
  assign M_AXI_ARLEN   = {NUM_M{S_AXI_ARLEN}};
  assign M_AXI_ARSIZE  = {NUM_M{S_AXI_ARSIZE}};
  assign M_AXI_ARBURST = {NUM_M{S_AXI_ARBURST}};
  assign M_AXI_ARLOCK  = {NUM_M{S_AXI_ARLOCK}};
  assign M_AXI_ARCACHE = {NUM_M{S_AXI_ARCACHE}};
  assign M_AXI_ARPROT  = {NUM_M{S_AXI_ARPROT}};

  logic [SelW-1:0] aw_sel, ar_sel;
  logic aw_err, ar_err, can_aw, can_ar, aw_hs, ar_hs, aw_rdy, ar_rdy;
  logic w_act, w_err, w_last_hs, b_act, bvalid, b_hs;
  logic r_act, r_err, rvalid, rlast, r_last_hs, r_hs;
  logic [ID_W-1:0] bid, rid;
  logic [1:0] bresp, rresp;
  logic [DATA_W-1:0] rdata;

  // Write address, data and response steering
  always_comb begin
    aw_sel = decode(S_AXI_AWADDR);
    aw_err = (aw_sel == ErrSel);
    // Only one error burst at a time, so ERR never joins an outstanding group.
    can_aw = RSTn && ((aw_cnt_q == '0) || ((aw_sel == w_tgt_q) && !aw_err)) &&
             (aw_cnt_q < MaxCnt);
    aw_rdy = aw_err;
    M_AXI_AWVALID = '0;
    w_act = RSTn && (wpend_q != '0);
    w_err = (w_tgt_q == ErrSel);
    S_AXI_WREADY = w_act && w_err;
    M_AXI_WVALID = '0;
    b_act  = RSTn && (aw_cnt_q != '0);
    bvalid = b_act && w_err && err_bvalid_q;
    bid    = err_bid_q;
    bresp  = 2'b11;
    M_AXI_BREADY = '0;
    for (int i = 0; i < NUM_M; i++) begin
      if (aw_sel == SelW'(i)) begin
        aw_rdy = M_AXI_AWREADY[i];
        M_AXI_AWVALID[i] = S_AXI_AWVALID && can_aw;
      end
      if (w_tgt_q == SelW'(i)) begin
        S_AXI_WREADY    = w_act && M_AXI_WREADY[i];
        M_AXI_WVALID[i] = w_act && S_AXI_WVALID;
        bvalid          = b_act && M_AXI_BVALID[i];
        bid             = M_AXI_BID[i*ID_W +: ID_W];
        bresp           = M_AXI_BRESP[i*2 +: 2];
        M_AXI_BREADY[i] = b_act && S_AXI_BREADY;
      end
    end
    S_AXI_AWREADY = can_aw && aw_rdy;
    aw_hs        = S_AXI_AWVALID && S_AXI_AWREADY;
    w_last_hs    = S_AXI_WVALID && S_AXI_WREADY && S_AXI_WLAST;
    S_AXI_BVALID = bvalid;
    S_AXI_BID    = bvalid ? bid : '0;
    S_AXI_BRESP  = bvalid ? bresp : 2'b00;
    b_hs         = bvalid && S_AXI_BREADY;
  end

  // Read address and data steering
  always_comb begin
    ar_sel = decode(S_AXI_ARADDR);
    ar_err = (ar_sel == ErrSel);
    can_ar = RSTn && ((ar_cnt_q == '0) || ((ar_sel == r_tgt_q) && !ar_err)) &&
             (ar_cnt_q < MaxCnt);
    ar_rdy = ar_err;
    M_AXI_ARVALID = '0;
    r_act  = RSTn && (ar_cnt_q != '0);
    r_err  = (r_tgt_q == ErrSel);
    rvalid = r_act && r_err && err_ract_q;
    rid    = err_rid_q;
    rdata  = '0;
    rresp  = 2'b11;
    rlast  = (err_rcnt_q == 8'd0);
    M_AXI_RREADY = '0;
    for (int i = 0; i < NUM_M; i++) begin
      if (ar_sel == SelW'(i)) begin
        ar_rdy = M_AXI_ARREADY[i];
        M_AXI_ARVALID[i] = S_AXI_ARVALID && can_ar;
      end
      if (r_tgt_q == SelW'(i)) begin
        rvalid          = r_act && M_AXI_RVALID[i];
        rid             = M_AXI_RID[i*ID_W +: ID_W];
        rdata           = M_AXI_RDATA[i*DATA_W +: DATA_W];
        rresp           = M_AXI_RRESP[i*2 +: 2];
        rlast           = M_AXI_RLAST[i];
        M_AXI_RREADY[i] = r_act && S_AXI_RREADY;
      end
    end
    S_AXI_ARREADY = can_ar && ar_rdy;
    ar_hs        = S_AXI_ARVALID && S_AXI_ARREADY;
    S_AXI_RVALID = rvalid;
    S_AXI_RID    = rvalid ? rid : '0;
    S_AXI_RDATA  = rvalid ? rdata : '0;
    S_AXI_RRESP  = rvalid ? rresp : 2'b00;
    S_AXI_RLAST  = rvalid && rlast;
    r_hs         = rvalid && S_AXI_RREADY;
    r_last_hs    = r_hs && rlast;
  end

  always_comb begin
    aw_cnt_d = aw_cnt_q;
    if (aw_hs && !b_hs)      aw_cnt_d = aw_cnt_q + CntW'(1);
    else if (!aw_hs && b_hs) aw_cnt_d = aw_cnt_q - CntW'(1);
    wpend_d = wpend_q;
    if (aw_hs && !w_last_hs)      wpend_d = wpend_q + CntW'(1);
    else if (!aw_hs && w_last_hs) wpend_d = wpend_q - CntW'(1);
    ar_cnt_d = ar_cnt_q;
    if (ar_hs && !r_last_hs)      ar_cnt_d = ar_cnt_q + CntW'(1);
    else if (!ar_hs && r_last_hs) ar_cnt_d = ar_cnt_q - CntW'(1);
  end

  always_ff @(posedge sys_clk or negedge RSTn) begin
    if (!RSTn) begin
      aw_cnt_q     <= '0;
      wpend_q      <= '0;
      ar_cnt_q     <= '0;
      w_tgt_q      <= '0;
      r_tgt_q      <= '0;
      err_bvalid_q <= 1'b0;
      err_bid_q    <= '0;
      err_ract_q   <= 1'b0;
      err_rid_q    <= '0;
      err_rcnt_q   <= '0;
    end else begin
      aw_cnt_q <= aw_cnt_d;
      wpend_q  <= wpend_d;
      ar_cnt_q <= ar_cnt_d;
      if (aw_hs) w_tgt_q <= aw_sel;
      if (ar_hs) r_tgt_q <= ar_sel;
      if (aw_hs && aw_err) err_bid_q <= S_AXI_AWID;
      // Error B goes out the cycle after WLAST is swallowed.
      if (w_last_hs && w_err)  err_bvalid_q <= 1'b1;
      else if (b_hs && w_err)  err_bvalid_q <= 1'b0;
      if (ar_hs && ar_err) begin
        err_ract_q <= 1'b1;
        err_rcnt_q <= S_AXI_ARLEN;
        err_rid_q  <= S_AXI_ARID;
      end else if (r_hs && r_err) begin
        if (rlast) err_ract_q <= 1'b0;
        else       err_rcnt_q <= err_rcnt_q - 8'd1;
      end
    end
  end

endmodule
